// File: rtl/led_pattern_gen.sv
// Multi-LED pattern generator: a prescaler produces a step tick that advances
// one of four runtime-selectable patterns (blink, alternate, chase, count).
module led_pattern_gen #(
    parameter int unsigned NUM_LEDS      = 4,
    parameter int unsigned CLKS_PER_STEP = 12_500_000
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic                i_Enable,
    input  logic [1:0]          i_Mode,
    output logic [NUM_LEDS-1:0] o_LED,
    output logic                o_Step
);

    localparam int unsigned PW = (CLKS_PER_STEP > 1) ? $clog2(CLKS_PER_STEP) : 1;
    localparam logic [PW-1:0]       LAST = PW'(CLKS_PER_STEP - 1);
    localparam logic [NUM_LEDS-1:0] ONE  = NUM_LEDS'(1);

    typedef enum logic [1:0] {
        MODE_BLINK     = 2'd0,
        MODE_ALTERNATE = 2'd1,
        MODE_CHASE     = 2'd2,
        MODE_COUNT     = 2'd3
    } mode_t;

    logic [PW-1:0]       presc;
    logic [NUM_LEDS-1:0] s;
    logic [NUM_LEDS-1:0] c;
    mode_t               m;

    logic                step_c;
    mode_t               mode_in_c;
    logic [NUM_LEDS-1:0] s_next_c;
    logic [NUM_LEDS-1:0] c_next_c;
    logic [NUM_LEDS-1:0] led_next_c;

    // LED image for a given mode, step count and chase position
    function automatic logic [NUM_LEDS-1:0] pattern(
        input mode_t               mode,
        input logic [NUM_LEDS-1:0] cnt,
        input logic [NUM_LEDS-1:0] hot
    );
        logic [NUM_LEDS-1:0] res;
        res = '0;
        case (mode)
            MODE_BLINK:     res = {NUM_LEDS{cnt[0]}};
            MODE_ALTERNATE: begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    res[i] = (i % 2 == 0) ? cnt[0] : ~cnt[0];
                end
            end
            MODE_CHASE:     res = hot;
            default:        res = cnt;
        endcase
        return res;
    endfunction

    // A mode change restarts the pattern from step 0, otherwise it advances
    always_comb begin
        step_c     = 1'b0;
        mode_in_c  = mode_t'(i_Mode);
        s_next_c   = s;
        c_next_c   = c;
        led_next_c = o_LED;

        step_c = i_Enable && (presc == LAST);
        if (mode_in_c != m) begin
            s_next_c = '0;
            c_next_c = ONE;
        end else begin
            s_next_c = s + ONE;
            c_next_c = {c[NUM_LEDS-2:0], c[NUM_LEDS-1]};
        end
        led_next_c = pattern(mode_in_c, s_next_c, c_next_c);
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            presc  <= '0;
            s      <= '0;
            c      <= ONE;
            m      <= MODE_BLINK;
            o_LED  <= '0;
            o_Step <= 1'b0;
        end else begin
            o_Step <= step_c;
            if (i_Enable) begin
                presc <= step_c ? '0 : presc + PW'(1);
            end
            if (step_c) begin
                m     <= mode_in_c;
                s     <= s_next_c;
                c     <= c_next_c;
                o_LED <= led_next_c;
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: directed test-plan scenarios followed by
// randomized mode/enable/reset traffic checked against a step-index model.
module tb_led_pattern_gen;

    localparam int N   = 4;
    localparam int CPS = 50;

    logic         i_Clk;
    logic         i_Rst;
    logic         i_Enable;
    logic [1:0]   i_Mode;
    logic [N-1:0] o_LED;
    logic         o_Step;

    led_pattern_gen #(.NUM_LEDS(N), .CLKS_PER_STEP(CPS)) dut (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Enable(i_Enable),
        .i_Mode  (i_Mode),
        .o_LED   (o_LED),
        .o_Step  (o_Step)
    );

    typedef struct {
        int           cyc;
        logic [N-1:0] led;
    } exp_t;

    exp_t         sb[$];
    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    logic [N-1:0] cur_led  = '0;

    // reference state: enabled edges since last step, active mode, steps since switch
    int en_cnt = 0;
    int mode_m = 0;
    int k      = 0;

    initial i_Clk = 1'b0;
    always #20 i_Clk = ~i_Clk;

    always @(posedge i_Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [N-1:0] pat(input int mode, input int kk);
        logic [N-1:0] r;
        logic         p;
        p = (kk % 2) == 1;
        r = '0;
        case (mode)
            0: r = p ? {N{1'b1}} : '0;
            1: for (int i = 0; i < N; i++) r[i] = (i % 2 == 0) ? p : !p;
            2: r = N'(1 << (kk % N));
            default: r = N'(kk % (1 << N));
        endcase
        return r;
    endfunction

    task automatic model_reset();
        en_cnt = 0;
        mode_m = 0;
        k      = 0;
    endtask

    // Predict the effect of the upcoming rising edge
    task automatic model_step(input logic en, input logic [1:0] mode);
        exp_t e;
        if (!en) return;
        en_cnt++;
        if (en_cnt == CPS) begin
            en_cnt = 0;
            if (int'(mode) != mode_m) begin
                mode_m = int'(mode);
                k      = 0;
            end else begin
                k++;
            end
            e.cyc = cyc + 1;
            e.led = pat(mode_m, k);
            sb.push_back(e);
        end
    endtask

    task automatic drive_cycle(input logic en, input logic [1:0] mode);
        @(negedge i_Clk);
        i_Enable = en;
        i_Mode   = mode;
        model_step(en, mode);
    endtask

    task automatic run(input int n, input logic en, input logic [1:0] mode);
        for (int i = 0; i < n; i++) drive_cycle(en, mode);
    endtask

    // Synchronous-looking reset; the release edge is modelled as enabled edge 1
    task automatic do_reset(input logic [1:0] mode);
        @(negedge i_Clk);
        i_Rst    = 1'b1;
        i_Enable = 1'b1;
        i_Mode   = mode;
        model_reset();
        #2;
        check("rst_led", 32'(o_LED), 32'd0);
        repeat (2) @(negedge i_Clk);
        i_Rst = 1'b0;
        model_step(1'b1, mode);
    endtask

    // Reset pulse strictly between two clock edges
    task automatic pulse_reset(input logic en, input logic [1:0] mode);
        drive_cycle(en, mode);
        @(posedge i_Clk);
        #5;
        i_Rst = 1'b1;
        model_reset();
        #3;
        check("async_rst_led", 32'(o_LED), 32'd0);
        check("async_rst_step", 32'(o_Step), 32'd0);
        #2;
        i_Rst = 1'b0;
    endtask

    task automatic at_edge(input string name, input logic [N-1:0] led, input logic step);
        @(posedge i_Clk);
        #2;
        check({name, "_led"}, 32'(o_LED), 32'(led));
        check({name, "_step"}, 32'(step), 32'(o_Step));
    endtask

    always @(posedge i_Rst) cur_led = '0;

    // Monitor: pop expected value on every step pulse, otherwise LEDs must hold
    initial begin
        exp_t e;
        forever begin
            @(posedge i_Clk);
            #1;
            if (i_Rst) begin
                check("mon_rst_led", 32'(o_LED), 32'd0);
                check("mon_rst_step", 32'(o_Step), 32'd0);
                cur_led = '0;
            end else if (o_Step) begin
                if (sb.size() == 0) begin
                    check("extra_step", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("step_cycle", 32'(cyc), 32'(e.cyc));
                    check("step_led", 32'(o_LED), 32'(e.led));
                    cur_led = e.led;
                end
            end else begin
                check("hold_led", 32'(o_LED), 32'(cur_led));
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog at cycle %0d: got timeout expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rm;
        int         len;
        i_Rst    = 1'b1;
        i_Enable = 1'b0;
        i_Mode   = 2'd0;

        // blink from reset
        do_reset(2'd0);
        run(49, 1'b1, 2'd0);
        at_edge("blink_on", 4'b1111, 1'b1);
        run(50, 1'b1, 2'd0);
        at_edge("blink_off", 4'b0000, 1'b1);

        // chase from reset
        do_reset(2'd2);
        run(49, 1'b1, 2'd2);
        at_edge("chase0", 4'b0001, 1'b1);
        run(50, 1'b1, 2'd2); at_edge("chase1", 4'b0010, 1'b1);
        run(50, 1'b1, 2'd2); at_edge("chase2", 4'b0100, 1'b1);
        run(50, 1'b1, 2'd2); at_edge("chase3", 4'b1000, 1'b1);
        run(50, 1'b1, 2'd2); at_edge("chase4", 4'b0001, 1'b1);
        run(50, 1'b1, 2'd2);
        run(50, 1'b1, 2'd2); at_edge("chase6", 4'b0100, 1'b1);

        // mode change to alternate at prescaler 20
        run(20, 1'b1, 2'd2);
        run(29, 1'b1, 2'd1);
        at_edge("alt_wait", 4'b0100, 1'b0);
        run(1, 1'b1, 2'd1);
        at_edge("alt0", 4'b1010, 1'b1);
        run(50, 1'b1, 2'd1);
        at_edge("alt1", 4'b0101, 1'b1);

        // 30 disabled cycles starting at prescaler 25
        run(25, 1'b1, 2'd1);
        run(30, 1'b0, 2'd1);
        run(24, 1'b1, 2'd1);
        at_edge("en_gap_pre", 4'b0101, 1'b0);
        run(1, 1'b1, 2'd1);
        at_edge("en_gap_step", 4'b1010, 1'b1);

        // count: switch step then 16 increments with wrap
        do_reset(2'd3);
        run(49, 1'b1, 2'd3);
        at_edge("count_sw", 4'b0000, 1'b1);
        for (int i = 1; i <= 16; i++) begin
            run(50, 1'b1, 2'd3);
            at_edge("count", 4'(i % 16), 1'b1);
        end

        // async reset pulse while counting at 0110
        for (int i = 0; i < 6; i++) run(50, 1'b1, 2'd3);
        at_edge("count6", 4'b0110, 1'b1);
        pulse_reset(1'b1, 2'd3);
        run(49, 1'b1, 2'd3);
        at_edge("post_rst_pre", 4'b0000, 1'b0);
        run(1, 1'b1, 2'd3);
        at_edge("post_rst_step", 4'b0000, 1'b1);

        // randomized traffic
        for (int seg = 0; seg < 90; seg++) begin
            rm  = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 120);
            if ($urandom_range(0, 14) == 0) pulse_reset(1'b1, rm);
            for (int i = 0; i < len; i++) begin
                drive_cycle($urandom_range(0, 99) < 85, rm);
            end
        end

        run(3, 1'b0, 2'd0);
        @(posedge i_Clk);
        #2;
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised multi-LED pattern generator for the 25 MHz board clock. It is the successor to the single-LED 1 Hz blinker and drives NUM_LEDS outputs in one of four runtime-selectable patterns. Patterns advance on a common step tick from an internal prescaler. Board switches feed the mode input, and LED pins connect to the output directly.

## Interface

Parameters:
- NUM_LEDS, 4: number of LED outputs; legal range ≥ 2.
- CLKS_PER_STEP, 12_500_000: clock cycles per pattern step; legal range ≥ 1. The default gives 1 Hz blink in mode 0 at 25 MHz.

Ports:
- i_Clk, in, 1: system clock.
- i_Rst, in, 1: reset, asynchronous and active-high.
- i_Enable, in, 1: prescaler run enable; low freezes all state.
- i_Mode, in, 2: requested pattern (0 BLINK, 1 ALTERNATE, 2 CHASE, 3 COUNT).
- o_LED, out, NUM_LEDS: registered LED drive; bit 0 = LED 1.
- o_Step, out, 1: one-cycle pulse that is high in the cycle where o_LED takes a new step value.

## Operation

Internal state:
- Prescaler, width ceil(log2(CLKS_PER_STEP)), minimum 1 bit.
- Step counter s, NUM_LEDS bits, wraps modulo 2^NUM_LEDS.
- One-hot chase register c, NUM_LEDS bits.
- Active mode register m, 2 bits.

Prescaler:
- Counts 0..CLKS_PER_STEP-1 while i_Enable=1, then wraps to 0.
- The step event is the edge where i_Enable=1 and prescaler = CLKS_PER_STEP-1.
- While i_Enable=0 the prescaler holds, no step event occurs, and s, c, m and o_LED hold.

At a step event:
- If i_Mode ≠ m: m <= i_Mode, s <= 0, c <= 1 (LED 1), and o_LED <= pattern(i_Mode, s=0, c=1).
- If i_Mode = m: s <= s+1, c rotates one position toward the MSB (MSB wraps to bit 0), and o_LED <= pattern(m, s+1, rotated c).
- o_Step <= 1 in both cases. On every other edge, o_Step <= 0.
- i_Mode changes between step events have no effect until the next step event.

Pattern functions (p = s[0]):
- BLINK: all bits = p.
- ALTERNATE: even-index bits = p, odd-index bits = ~p.
- CHASE: o_LED = c.
- COUNT: o_LED = s.

Reset (asynchronous, takes effect immediately without waiting for a clock edge):
- Prescaler = 0, s = 0, c = 1, m = 0 (BLINK).
- o_LED = all 0, o_Step = 0.
- State holds while i_Rst = 1.

## Timing

- The first step event occurs on the CLKS_PER_STEP-th rising edge after i_Rst deasserts with i_Enable=1 throughout. o_LED and o_Step change on that edge.
- Step spacing is exactly CLKS_PER_STEP enabled cycles. BLINK full period = 2·CLKS_PER_STEP cycles. CHASE revolution = NUM_LEDS steps. COUNT wraps after 2^NUM_LEDS steps.
- Latency from a stable i_Mode change to the new pattern is up to CLKS_PER_STEP cycles, applied at the next step boundary.
- Disabled cycles add 1:1 to the current step interval. The prescaler resumes from its held value.
- CLKS_PER_STEP=1: a step event occurs on every enabled edge and o_Step stays high continuously.
- Reset asserted mid-step discards the partial count. Timing restarts from prescaler 0 after release.

## Test plan

Bench configuration for all scenarios: NUM_LEDS=4, CLKS_PER_STEP=50, clock period 40 ns.

1. Reset release with i_Mode=0, i_Enable=1:
   - o_LED=0000 during reset.
   - o_LED goes to 1111 at edge 50, then 0000 at edge 100.
   - o_Step is high exactly one cycle at each of those edges.
2. i_Mode=2 held from reset:
   - At the first boundary, o_LED=0001.
   - Subsequent boundaries, every 50 cycles: 0010, 0100, 1000, 0001.
3. i_Mode=3 held:
   - After the mode-switch step, o_LED=0000.
   - o_LED then increments each step through 1111 and wraps to 0000 on the 16th step after the switch.
4. Mode change mid-step: in CHASE with o_LED=0100, set i_Mode=1 at prescaler 20.
   - o_LED stays 0100 until the boundary 30 cycles later.
   - At that boundary o_LED=1010; the next step gives 0101.
5. i_Enable low for 30 cycles starting at prescaler 25:
   - The step occurs 80 cycles after the previous step.
   - o_LED and o_Step are frozen while disabled.
6. i_Rst pulsed between clock edges mid-run (COUNT at 0110):
   - o_LED reads 0000 before the next clock edge, and o_Step reads 0.
   - After release, the first step lands exactly 50 edges later.
